// File: rtl/gcd_engine_if.sv
// rtl/gcd_engine_if.sv - request/result port bundle for the GCD accelerator
interface gcd_engine_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = WIDTH + 1
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             error;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, mode, a, b,
        input  busy, done, error, y, cycles
    );

    modport slave (
        input  start, mode, a, b,
        output busy, done, error, y, cycles
    );
endinterface

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - multi-cycle GCD engine, subtractive (Euclid) or binary (Stein) per request
module gcd_engine #(
    parameter int WIDTH = 16,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    gcd_engine_if.slave  bus
);
    localparam int KW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic [KW-1:0]    k_q, k_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;

    logic             accept;
    logic [CNT_W-1:0] cnt_inc;

    assign accept  = bus.start && (state_q != ST_CALC);
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        k_d      = k_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        y_d      = y_q;
        err_d    = err_q;
        cycles_d = cycles_q;

        if (accept) begin
            ra_d     = bus.a;
            rb_d     = bus.b;
            mode_d   = bus.mode;
            k_d      = '0;
            cnt_d    = '0;
            cycles_d = '0;
            if (bus.a == '0 || bus.b == '0) begin
                // Zero operand: report the other operand without iterating.
                err_d   = 1'b1;
                y_d     = bus.a | bus.b;
                state_d = ST_FIN;
            end else begin
                err_d   = 1'b0;
                state_d = ST_CALC;
            end
        end else if (state_q == ST_CALC) begin
            cnt_d = cnt_inc;
            if (ra_q == rb_q) begin
                y_d      = mode_q ? (ra_q << k_q) : ra_q;
                cycles_d = cnt_inc;
                state_d  = ST_FIN;
            end else if (mode_q && !ra_q[0] && !rb_q[0]) begin
                ra_d = ra_q >> 1;
                rb_d = rb_q >> 1;
                k_d  = k_q + KW'(1);
            end else if (mode_q && !ra_q[0]) begin
                ra_d = ra_q >> 1;
            end else if (mode_q && !rb_q[0]) begin
                rb_d = rb_q >> 1;
            end else if (ra_q > rb_q) begin
                // Both binary-odd and subtractive steps: larger minus smaller.
                ra_d = ra_q - rb_q;
            end else begin
                rb_d = rb_q - ra_q;
            end
        end else if (state_q == ST_FIN) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ra_q     <= '0;
            rb_q     <= '0;
            k_q      <= '0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            y_q      <= y_d;
            err_q    <= err_d;
            cycles_q <= cycles_d;
        end
    end

    assign bus.busy   = (state_q == ST_CALC);
    assign bus.done   = (state_q == ST_FIN);
    assign bus.error  = err_q;
    assign bus.y      = y_q;
    assign bus.cycles = cycles_q;
endmodule
